// File: rtl/ura_ctrl_pkg.sv
// Shared definitions for the UltraRAM port controller.
//   - default parameter constants for address/data width, output pipeline
//     depth and response FIFO depth
//   - ura_req_t: request (we, addr, wdata) at the default widths
//   - rd_lat(): RAM read latency in edges for a given output pipeline depth
package ura_ctrl_pkg;
   localparam int URA_AWIDTH_DEF    = 12;
   localparam int URA_DWIDTH_DEF    = 72;
   localparam int URA_NBPIPE_DEF    = 3;
   localparam int URA_RSP_DEPTH_DEF = 8;

   typedef struct packed {
      logic                      we;
      logic [URA_AWIDTH_DEF-1:0] addr;
      logic [URA_DWIDTH_DEF-1:0] wdata;
   } ura_req_t;

   // Edges from the edge that samples ram_en=1 to the edge that updates ram_dout.
   function automatic int rd_lat(input int nbpipe);
      return nbpipe + 1;
   endfunction
endpackage

// File: rtl/ura_rsp_fifo.sv
// First-word fall-through response FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push, din  : write port; a push at full is taken only with a same-edge pop
//   pop        : take the head; ignored while empty
//   dout       : head entry, forced to 0 while empty
//   count      : occupancy 0..RSP_DEPTH
//   full/empty : occupancy flags
module ura_rsp_fifo #(
   parameter int DWIDTH    = 72,
   parameter int RSP_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [DWIDTH-1:0]          din,
   input  logic                       pop,
   output logic [DWIDTH-1:0]          dout,
   output logic [$clog2(RSP_DEPTH):0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = PW + 1;

   logic [DWIDTH-1:0] mem [RSP_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              push_en;
   logic              pop_en;

   assign empty   = (count == '0);
   assign full    = (count == CW'(RSP_DEPTH));
   assign pop_en  = pop && !empty;
   assign push_en = push && (!full || pop_en);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Depth is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
         if (push_en && !pop_en)      count <= count + 1'b1;
         else if (pop_en && !push_en) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/ultraram_port_ctrl.sv
// Request/response front end for a single-port UltraRAM with NBPIPE output
// pipeline registers.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_*               : request channel (valid/ready); reads are credit gated
//   rsp_*               : in-order read data, valid/ready
//   ram_*               : registered RAM controls, ram_dout back from the RAM
//   rd_inflight         : reads accepted but not yet written into the FIFO
// The RAM cannot stall, so a read is only accepted while the FIFO is
// guaranteed to have room for its data when it comes back.
module ultraram_port_ctrl import ura_ctrl_pkg::*; #(
   parameter int AWIDTH    = URA_AWIDTH_DEF,
   parameter int DWIDTH    = URA_DWIDTH_DEF,
   parameter int NBPIPE    = URA_NBPIPE_DEF,
   parameter int RSP_DEPTH = URA_RSP_DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_we,
   input  logic [AWIDTH-1:0]          req_addr,
   input  logic [DWIDTH-1:0]          req_wdata,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DWIDTH-1:0]          rsp_rdata,
   output logic                       ram_rst,
   output logic                       ram_en,
   output logic                       ram_we,
   output logic                       ram_regce,
   output logic [AWIDTH-1:0]          ram_addr,
   output logic [DWIDTH-1:0]          ram_din,
   input  logic [DWIDTH-1:0]          ram_dout,
   output logic [$clog2(RSP_DEPTH):0] rd_inflight
);
   localparam int RD_LAT = rd_lat(NBPIPE);
   localparam int CW     = $clog2(RSP_DEPTH) + 1;
   localparam int SW     = CW + 1;

   typedef struct packed {
      logic              we;
      logic [AWIDTH-1:0] addr;
      logic [DWIDTH-1:0] wdata;
   } req_t;

   req_t          req;
   logic          ready_en;
   logic          accept;
   logic          rd_accept;
   logic          rd_blocked;
   logic [SW-1:0] credit_used;
   logic [RD_LAT:0] vld_pipe;
   logic          fifo_push;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;

   assign req = '{we: req_we, addr: req_addr, wdata: req_wdata};

   // Every read accepted holds a FIFO slot until its data is popped.
   assign credit_used = {1'b0, rd_inflight} + {1'b0, fifo_count};
   assign rd_blocked  = fifo_full || (credit_used >= SW'(RSP_DEPTH));
   assign req_ready   = ready_en && !(!req.we && rd_blocked);
   assign accept      = req_valid && req_ready;
   assign rd_accept   = accept && !req.we;

   // The RAM output stage is held in reset with the block.
   assign ram_regce = rst_n;
   assign ram_rst   = ~rst_n;

   // vld_pipe[0] is loaded on the edge that samples ram_en; the tag leaves
   // vld_pipe[RD_LAT] one edge after ram_dout has been updated.
   assign fifo_push = vld_pipe[RD_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en    <= 1'b0;
         ram_en      <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_din     <= '0;
         vld_pipe    <= '0;
         rd_inflight <= '0;
      end else begin
         ready_en <= 1'b1;
         ram_en   <= accept;
         ram_we   <= accept && req.we;
         if (accept) begin
            ram_addr <= req.addr;
            ram_din  <= req.wdata;
         end
         vld_pipe <= {vld_pipe[RD_LAT-1:0], ram_en && !ram_we};
         if (rd_accept && !fifo_push)      rd_inflight <= rd_inflight + 1'b1;
         else if (fifo_push && !rd_accept) rd_inflight <= rd_inflight - 1'b1;
      end
   end

   ura_rsp_fifo #(
      .DWIDTH   (DWIDTH),
      .RSP_DEPTH(RSP_DEPTH)
   ) u_rsp_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (fifo_push),
      .din  (ram_dout),
      .pop  (rsp_ready),
      .dout (rsp_rdata),
      .count(fifo_count),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   assign rsp_valid = !fifo_empty;
endmodule

// File: tb/tb_ultraram_port_ctrl.sv
// Bench for ultraram_port_ctrl with a single-port UltraRAM behavioural model
// (ram_dout updates RD_LAT edges after the edge that samples a read).
// Expected read data comes from a reference memory updated at request
// acceptance; a monitor pops the expected queue on every rsp handshake.
module tb_ultraram_port_ctrl;
   import ura_ctrl_pkg::*;

   localparam int AW     = URA_AWIDTH_DEF;
   localparam int DW     = URA_DWIDTH_DEF;
   localparam int NBP    = URA_NBPIPE_DEF;
   localparam int DEPTH  = URA_RSP_DEPTH_DEF;
   localparam int RD_LAT = rd_lat(NBP);
   localparam int CW     = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          ram_rst, ram_en, ram_we, ram_regce;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din, ram_dout;
   logic [CW-1:0] rd_inflight;

   logic          f_push, f_pop, f_full, f_empty;
   logic [DW-1:0] f_din, f_dout;
   logic [CW-1:0] f_count;

   int tests   = 0;
   int fails   = 0;
   int cyc     = 0;
   int acc_cyc = 0;
   int rsp_cnt = 0;

   logic [DW-1:0] ref_mem [int];
   logic [DW-1:0] exp_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ultraram_port_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .NBPIPE(NBP), .RSP_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .ram_rst(ram_rst), .ram_en(ram_en), .ram_we(ram_we), .ram_regce(ram_regce),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .rd_inflight(rd_inflight)
   );

   ura_rsp_fifo #(.DWIDTH(DW), .RSP_DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(f_push), .din(f_din), .pop(f_pop),
      .dout(f_dout), .count(f_count), .full(f_full), .empty(f_empty)
   );

   // Single-port UltraRAM model: unwritten locations read as zero.
   logic [DW-1:0] ram_mem [int];
   logic [DW-1:0] ram_pipe [0:RD_LAT];
   assign ram_dout = ram_pipe[RD_LAT];

   always @(posedge clk) begin
      if (ram_rst) begin
         for (int i = 0; i <= RD_LAT; i++) ram_pipe[i] <= '0;
      end else begin
         if (ram_en && ram_we) ram_mem[int'(ram_addr)] = ram_din;
         if (ram_en && !ram_we)
            ram_pipe[0] <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : '0;
         if (ram_regce)
            for (int i = 1; i <= RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[DW-1:0];
   endfunction

   function automatic ura_req_t mk(input logic we, input int a, input logic [DW-1:0] d);
      ura_req_t r;
      r.we    = we;
      r.addr  = AW'(a);
      r.wdata = d;
      return r;
   endfunction

   // One cycle of stimulus: drive at negedge, decide acceptance before the
   // next posedge and update the reference model accordingly.
   task automatic drive(input logic v, input ura_req_t r, input logic rr, output logic acc);
      @(negedge clk);
      req_valid = v;
      req_we    = r.we;
      req_addr  = r.addr;
      req_wdata = r.wdata;
      rsp_ready = rr;
      #1;
      acc = v && req_ready;
      if (acc) begin
         acc_cyc = cyc + 1;
         if (r.we) ref_mem[int'(r.addr)] = r.wdata;
         else exp_q.push_back(ref_mem.exists(int'(r.addr)) ? ref_mem[int'(r.addr)] : '0);
      end
   endtask

   task automatic idle(input int n, input logic rr);
      logic a;
      repeat (n) drive(1'b0, '0, rr, a);
   endtask

   initial begin : monitor
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && rsp_valid && rsp_ready) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rsp_extra: got %0h, want no response", rsp_rdata);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_data", rsp_rdata, e);
            end
         end
      end
   end

   initial begin : main
      logic          acc;
      int            n, lat, seen, rc0;
      logic [DW-1:0] fq [$];

      rst_n = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      f_push = 1'b0; f_pop = 1'b0; f_din = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_din", ram_din, 0);
      chk("rst_ram_regce", ram_regce, 0);
      chk("rst_ram_rst", ram_rst, 1);
      chk("rst_rd_inflight", rd_inflight, 0);

      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("ready_before_first_edge", req_ready, 0);
      @(posedge clk);
      #1;
      chk("ready_after_first_edge", req_ready, 1);
      chk("regce_run", ram_regce, 1);
      chk("ram_rst_run", ram_rst, 0);

      // Write then read the same address on the next cycle.
      drive(1'b1, mk(1'b1, 5, 72'h0AA), 1'b1, acc);
      chk("wr_accept", acc, 1);
      @(posedge clk);
      #1;
      chk("wr_ram_en", ram_en, 1);
      chk("wr_ram_we", ram_we, 1);
      chk("wr_ram_addr", ram_addr, 5);
      chk("wr_ram_din", ram_din, 72'h0AA);
      drive(1'b1, mk(1'b0, 5, '0), 1'b1, acc);
      chk("rd_accept", acc, 1);
      lat = 0;
      for (int k = 0; k < 20 && lat == 0; k++) begin
         idle(1, 1'b1);
         if (rsp_valid) begin
            lat = cyc - acc_cyc;
            chk("rd_after_wr_data", rsp_rdata, 72'h0AA);
         end
      end
      chk("rd_latency", lat, NBP + 3);

      // Credit exhaustion with the consumer stalled.
      idle(10, 1'b1);
      n = 0;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, mk(1'b0, $urandom_range(0, 15), '0), 1'b0, acc);
         n += int'(acc);
      end
      chk("credit_reads", n, DEPTH);
      drive(1'b1, mk(1'b0, 3, '0), 1'b0, acc);
      chk("rd_blocked_at_credit", acc, 0);
      drive(1'b1, mk(1'b1, $urandom_range(16, 31), rnd_data()), 1'b0, acc);
      chk("wr_at_credit", acc, 1);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, mk(1'b0, 7, '0), 1'b0, acc);
         n += int'(acc);
      end
      chk("rd_blocked_hold", n, 0);
      chk("inflight_drained", rd_inflight, 0);
      rc0 = rsp_cnt;
      drive(1'b1, mk(1'b0, 7, '0), 1'b1, acc);
      chk("rd_blocked_at_pop_edge", acc, 0);
      drive(1'b1, mk(1'b0, 7, '0), 1'b1, acc);
      chk("rd_resume", acc, 1);
      idle(20, 1'b1);
      chk("credit_rsp_count", rsp_cnt - rc0, DEPTH + 1);

      // Alternating write/read, one request per cycle.
      rc0 = rsp_cnt;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, mk(1'b1, i, rnd_data()), 1'b1, acc);
         n += int'(acc);
         drive(1'b1, mk(1'b0, i, '0), 1'b1, acc);
         n += int'(acc);
      end
      idle(12, 1'b1);
      chk("alt_accepts", n, 32);
      chk("alt_rsp_count", rsp_cnt - rc0, 16);

      // Reset with three reads in flight.
      idle(4, 1'b1);
      for (int i = 0; i < 3; i++) drive(1'b1, mk(1'b0, $urandom_range(0, 15), '0), 1'b1, acc);
      @(negedge clk);
      req_valid = 1'b0;
      #1 chk("inflight_before_reset", rd_inflight, 3);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("inflight_in_reset", rd_inflight, 0);
      chk("ram_en_in_reset", ram_en, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         idle(1, 1'b1);
         seen += int'(rsp_valid);
      end
      chk("no_rsp_after_reset", seen, 0);
      chk("inflight_after_reset", rd_inflight, 0);

      // FIFO held full, then push and pop on the same edge.
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         f_push = 1'b1;
         f_din  = DW'(i + 1);
         fq.push_back(DW'(i + 1));
      end
      @(negedge clk);
      f_push = 1'b0;
      #1;
      chk("fifo_full_count", f_count, DEPTH);
      chk("fifo_full_flag", f_full, 1);
      @(negedge clk);
      f_push = 1'b1; f_pop = 1'b1; f_din = 72'h100;
      void'(fq.pop_front());
      fq.push_back(72'h100);
      @(negedge clk);
      f_push = 1'b0; f_pop = 1'b0;
      #1;
      chk("fifo_pushpop_count", f_count, DEPTH);
      chk("fifo_pushpop_full", f_full, 1);
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         f_pop = 1'b0;
         #1;
         chk("fifo_order", f_dout, fq[i]);
         f_pop = 1'b1;
      end
      @(negedge clk);
      f_pop = 1'b0;
      #1 chk("fifo_drained_empty", f_empty, 1);

      // Random traffic against the reference model.
      idle(2, 1'b1);
      for (int c = 0; c < 10000; c++) begin
         drive($urandom_range(0, 9) < 7,
               mk(1'($urandom_range(0, 1)), $urandom_range(0, 31), rnd_data()),
               $urandom_range(0, 9) < 6, acc);
      end
      idle(30, 1'b1);
      chk("no_lost_rsp", exp_q.size(), 0);
      chk("random_inflight_idle", rd_inflight, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
